// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths, write-request type and arbiter state encoding
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [REG_DW-1:0] wd;
  } wr_req_t;

  localparam logic [0:0] ARB_NORMAL = 1'b0;
  localparam logic [0:0] ARB_FORCE  = 1'b1;

endpackage

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - secondary write queue; exposes per-entry valid/a3 for pending-write decode
module rf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_a3_i,
  input  logic [DW-1:0]            push_wd_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [AW-1:0]            head_a3_o,
  output logic [DW-1:0]            head_wd_o,
  output logic [DEPTH-1:0]         ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0] ent_a3_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] a3_mem_q;
  logic [DEPTH-1:0][DW-1:0] wd_mem_q;
  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            count_d;
  logic                     do_push;
  logic                     do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_a3_o = a3_mem_q[rd_ptr_q];
  assign head_wd_o = wd_mem_q[rd_ptr_q];
  assign ent_a3_o  = a3_mem_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_mem_q <= '0;
      wd_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        a3_mem_q[wr_ptr_q] <= push_a3_i;
        wd_mem_q[wr_ptr_q] <= push_wd_i;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between WB and a queued secondary writer
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int AW       = REG_AW,
  parameter int DW       = REG_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_a3,
  input  logic [DW-1:0]    wb_wd,
  output logic             wb_stall,
  input  logic             sec_valid,
  output logic             sec_ready,
  input  logic [AW-1:0]    sec_a3,
  input  logic [DW-1:0]    sec_wd,
  output logic             rf_we,
  output logic [AW-1:0]    rf_a3,
  output logic [DW-1:0]    rf_wd,
  output logic [2**AW-1:0] busy_mask,
  output logic             waw_err
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  logic [0:0]              state_q;
  logic [0:0]              state_d;
  logic [WCW-1:0]          wait_cnt_q;
  logic [WCW-1:0]          wait_cnt_d;
  logic                    waw_q;
  logic                    waw_d;

  logic                    wb_slot_busy;
  logic                    q_push;
  logic                    q_pop;
  logic                    q_full;
  logic                    q_empty;
  logic [AW-1:0]           head_a3;
  logic [DW-1:0]           head_wd;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_a3;

  assign wb_slot_busy = wb_we && (wb_a3 != '0);

  // Writes to r0 complete the handshake but never occupy a queue slot.
  assign q_push    = sec_valid && !q_full && (sec_a3 != '0);
  assign sec_ready = !q_full;

  rf_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (q_push),
    .push_a3_i   (sec_a3),
    .push_wd_i   (sec_wd),
    .pop_i       (q_pop),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_a3_o   (head_a3),
    .head_wd_o   (head_wd),
    .ent_valid_o (ent_valid),
    .ent_a3_o    (ent_a3)
  );

  always_comb begin
    state_d    = ARB_NORMAL;
    wait_cnt_d = wait_cnt_q;
    q_pop      = 1'b0;
    wb_stall   = 1'b0;
    rf_we      = 1'b0;
    rf_a3      = '0;
    rf_wd      = '0;
    if (state_q == ARB_FORCE) begin
      wb_stall   = 1'b1;
      wait_cnt_d = '0;
      if (!q_empty) begin
        rf_we = 1'b1;
        rf_a3 = head_a3;
        rf_wd = head_wd;
        q_pop = 1'b1;
      end
    end else if (wb_slot_busy) begin
      rf_we = 1'b1;
      rf_a3 = wb_a3;
      rf_wd = wb_wd;
      if (!q_empty) begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ARB_FORCE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    end else if (!q_empty) begin
      rf_we      = 1'b1;
      rf_a3      = head_a3;
      rf_wd      = head_wd;
      q_pop      = 1'b1;
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        busy_mask[ent_a3[i]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  assign waw_d   = waw_q || ((state_q == ARB_NORMAL) && wb_slot_busy && busy_mask[wb_a3]);
  assign waw_err = waw_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_NORMAL;
      wait_cnt_q <= '0;
      waw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      waw_q      <= waw_d;
    end
  end

endmodule
